// File: rtl/icache_axi_rd_bridge_if.sv
// Signal bundle between the icache refill port, the read bridge and the AXI AR/R channels.
interface icache_axi_rd_bridge_if;
  logic         rd_req;
  logic         rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic [255:0] ret_data;

  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [1:0]   arlock;
  logic [3:0]   arcache;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  modport master (
    input  rd_req, rd_type, rd_addr, arready, rid, rdata, rresp, rlast, rvalid,
    output rd_rdy, ret_valid, ret_data,
           arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready
  );

  modport slave (
    output rd_req, rd_type, rd_addr, arready, rid, rdata, rresp, rlast, rvalid,
    input  rd_rdy, ret_valid, ret_data,
           arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready
  );
endinterface

// File: rtl/icache_axi_rd_bridge.sv
// Read-only AXI master serving icache refills: one 8-beat line or one uncached word at a time,
// returned as a single-cycle ret_valid pulse with the assembled 256-bit buffer.
module icache_axi_rd_bridge #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input logic                    clk,
  input logic                    resetn,
  icache_axi_rd_bridge_if.master bus
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    AR   = 4'b0010,
    R    = 4'b0100,
    RET  = 4'b1000
  } state_t;

  state_t       state, state_nx;
  logic         type_q;
  logic [31:0]  addr_q;
  logic [2:0]   cnt_q;
  logic [255:0] line_q;
  logic         accept;
  logic         beat;

  assign accept = (state == IDLE) && bus.rd_req;
  assign beat   = (state == R) && bus.rvalid;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.rd_req)              state_nx = AR;
      AR:      if (bus.arready)             state_nx = R;
      R:       if (bus.rvalid && bus.rlast) state_nx = RET;
      RET:                                  state_nx = IDLE;
      default:                              state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.rd_rdy    = (state == IDLE);
    bus.arvalid   = (state == AR);
    bus.rready    = (state == R);
    bus.ret_valid = (state == RET);
  end

  // Line requests are forced onto a 32-byte boundary so the INCR burst covers exactly one line.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      type_q <= 1'b0;
      addr_q <= '0;
      cnt_q  <= '0;
      line_q <= '0;
    end else if (accept) begin
      type_q <= bus.rd_type;
      addr_q <= bus.rd_type ? {bus.rd_addr[31:5], 5'b0} : bus.rd_addr;
      cnt_q  <= '0;
      line_q <= '0;
    end else if (beat) begin
      line_q[{cnt_q, 5'b0} +: 32] <= bus.rdata;
      cnt_q                       <= cnt_q + 3'd1;
    end
  end

  assign bus.arid     = AXI_ID;
  assign bus.araddr   = addr_q;
  assign bus.arlen    = type_q ? 8'd7 : 8'd0;
  assign bus.arsize   = 3'b010;
  assign bus.arburst  = 2'b01;
  assign bus.arlock   = '0;
  assign bus.arcache  = '0;
  assign bus.arprot   = '0;
  assign bus.ret_data = line_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.rid, bus.rresp};

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Randomized bench for icache_axi_rd_bridge: an AXI slave model plus a line-level reference
// that predicts burst address/length, returned line contents and cycle latency.
module tb_icache_axi_rd_bridge;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  icache_axi_rd_bridge_if bus ();

  icache_axi_rd_bridge #(.AXI_ID(4'd5)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] beat_word(input int mode, input int k);
    case (mode)
      1:       beat_word = 32'h1111_1111 * (k + 1);
      2:       beat_word = 32'hDEAD_BEEF;
      default: beat_word = $urandom;
    endcase
  endfunction

  // One cache request end to end; abort_at>0 resets the bridge right after that beat.
  task automatic do_read(input bit typ, input logic [31:0] addr, input int ar_delay,
                         input int bubble_pct, input int mode, input bit hold_next,
                         input bit ntyp, input logic [31:0] naddr, input int abort_at);
    logic [255:0] exp_line;
    logic [31:0]  exp_addr;
    logic [31:0]  w;
    int           nbeats;
    int           lat;
    int           stalls;
    int           waits;
    exp_line = '0;
    exp_addr = typ ? (addr & 32'hFFFF_FFE0) : addr;
    nbeats   = typ ? 8 : 1;
    lat      = 0;
    stalls   = 0;
    waits    = 0;

    bus.rd_req  = 1'b1;
    bus.rd_type = typ;
    bus.rd_addr = addr;
    while (bus.rd_rdy !== 1'b1) begin
      step();
      waits++;
      if (waits > 50) begin
        check("accept_timeout", 0, 1);
        bus.rd_req = 1'b0;
        return;
      end
    end
    step();
    if (hold_next) begin
      bus.rd_type = ntyp;
      bus.rd_addr = naddr;
    end else begin
      bus.rd_req = 1'b0;
    end
    lat = 1;

    check("arvalid_after_accept", bus.arvalid, 1);
    check("rd_rdy_in_ar", bus.rd_rdy, 0);
    check("araddr", bus.araddr, exp_addr);
    check("arlen", bus.arlen, typ ? 8'd7 : 8'd0);
    check("arsize", bus.arsize, 3'b010);
    check("arburst", bus.arburst, 2'b01);
    check("arid", bus.arid, 4'd5);
    check("ar_misc_zero", {bus.arlock, bus.arcache, bus.arprot}, 0);

    for (int i = 0; i < ar_delay; i++) begin
      step();
      lat++;
      check("arvalid_held", bus.arvalid, 1);
      check("araddr_stable", bus.araddr, exp_addr);
      check("arlen_stable", bus.arlen, typ ? 8'd7 : 8'd0);
    end
    bus.arready = 1'b1;
    step();
    lat++;
    bus.arready = 1'b0;
    check("arvalid_dropped", bus.arvalid, 0);
    check("rready_after_ar", bus.rready, 1);

    for (int k = 0; k < nbeats; k++) begin
      int s;
      s = 0;
      while ($urandom_range(99) < bubble_pct && s < 6) begin
        bus.rvalid = 1'b0;
        step();
        lat++;
        stalls++;
        s++;
        check("rready_bubble", bus.rready, 1);
      end
      w = beat_word(mode, k);
      exp_line[k*32 +: 32] = w;
      bus.rvalid = 1'b1;
      bus.rdata  = w;
      bus.rlast  = (k == nbeats - 1);
      bus.rresp  = 2'($urandom);
      bus.rid    = 4'($urandom);
      step();
      lat++;
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      if (abort_at == k + 1) begin
        resetn = 1'b0;
        step();
        check("rst_rd_rdy", bus.rd_rdy, 1);
        check("rst_ctrl_low", {bus.arvalid, bus.rready, bus.ret_valid}, 0);
        check("rst_ret_data", bus.ret_data, 0);
        check("rst_ar_regs", {bus.araddr, bus.arlen}, 0);
        resetn = 1'b1;
        step();
        check("rst_released_idle", bus.rd_rdy, 1);
        return;
      end
      if (k < nbeats - 1) begin
        check("no_early_ret", bus.ret_valid, 0);
        check("rd_rdy_in_r", bus.rd_rdy, 0);
      end
    end

    check("ret_valid", bus.ret_valid, 1);
    check("ret_data", bus.ret_data, exp_line);
    check("rd_rdy_in_ret", bus.rd_rdy, 0);
    check("latency", lat, 2 + ar_delay + stalls + nbeats);
    step();
    check("ret_single_pulse", bus.ret_valid, 0);
    check("rd_rdy_after_ret", bus.rd_rdy, 1);
    check("ret_data_hold", bus.ret_data, exp_line);
  endtask

  initial begin
    bus.rd_req  = 1'b0;
    bus.rd_type = 1'b0;
    bus.rd_addr = '0;
    bus.arready = 1'b0;
    bus.rid     = '0;
    bus.rdata   = '0;
    bus.rresp   = '0;
    bus.rlast   = 1'b0;
    bus.rvalid  = 1'b0;
    resetn      = 1'b0;
    step();
    step();
    check("reset_rd_rdy", bus.rd_rdy, 1);
    check("reset_ctrl", {bus.arvalid, bus.rready, bus.ret_valid}, 0);
    check("reset_ret_data", bus.ret_data, 0);
    check("reset_ar_regs", {bus.araddr, bus.arlen}, 0);
    resetn = 1'b1;
    step();

    do_read(1'b1, 32'h1FC0_0014, 0, 0, 1, 1'b0, 1'b0, '0, 0);
    do_read(1'b0, 32'hBFC0_0004, 0, 0, 2, 1'b0, 1'b0, '0, 0);
    do_read(1'b1, 32'h1FC0_0014, 5, 40, 1, 1'b0, 1'b0, '0, 0);
    do_read(1'b1, 32'h0000_1234, 1, 20, 0, 1'b1, 1'b0, 32'h0000_2042, 0);
    do_read(1'b0, 32'h0000_2042, 0, 0, 0, 1'b0, 1'b0, '0, 0);
    do_read(1'b1, 32'h8000_0100, 1, 20, 0, 1'b0, 1'b0, '0, 3);
    do_read(1'b1, 32'h8000_0104, 0, 0, 1, 1'b0, 1'b0, '0, 0);

    for (int n = 0; n < 20; n++) begin
      do_read(1'($urandom), $urandom, $urandom_range(3), 30, 0, 1'b0, 1'b0, '0, 0);
      repeat ($urandom_range(2)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/icache_axi_rd_bridge.md
# icache_axi_rd_bridge

Read-only AXI3/AXI4 master that serves the instruction cache's refill port. It accepts one cache read request at a time: a full 256-bit line (8 × 32-bit INCR burst) or a single uncached 32-bit word. It drives the AXI AR/R channels and assembles the returned beats. It then hands the result back to the cache as a single-cycle `ret_valid` pulse. It sits between the icache and the SoC AXI crossbar.

## Interface
- `AXI_ID`, default 4'd0: constant driven on `arid`.
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `rd_req`  in  1  cache read request; held by the cache until accepted.
- `rd_type`  in  1  1 = cache line (8 beats), 0 = uncached single word.
- `rd_addr`  in  32  request byte address.
- `rd_rdy`  out  1  bridge can accept; a request is accepted when `rd_req && rd_rdy`.
- `ret_valid`  out  1  one-cycle pulse; `ret_data` is valid.
- `ret_data`  out  256  returned line; word i in bits [32i+31:32i].
- `arid`  out  4  = `AXI_ID`.
- `araddr`  out  32  burst address.
- `arlen`  out  8  7 for a line, 0 for uncached.
- `arsize`  out  3  constant 3'b010.
- `arburst`  out  2  constant 2'b01 (INCR).
- `arlock`  out  2  constant 0.
- `arcache`  out  4  constant 0.
- `arprot`  out  3  constant 0.
- `arvalid`  out  1  AR valid.
- `arready`  in  1  AR ready.
- `rid`  in  4  ignored.
- `rdata`  in  32  read beat data.
- `rresp`  in  2  ignored; data is forwarded regardless of the response.
- `rlast`  in  1  last beat.
- `rvalid`  in  1  R valid.
- `rready`  out  1  R ready.

## Operation
- One-hot FSM with four states:
  - IDLE: `rd_rdy`=1.
  - AR: `arvalid`=1.
  - R: `rready`=1.
  - RET: `ret_valid`=1.
- All four of these outputs are decoded from the state only; none depend combinationally on inputs.
- IDLE → AR on `rd_req && rd_rdy`. On that edge the bridge:
  - latches `rd_type`;
  - latches the address: for a line, {`rd_addr`[31:5], 5'b0}, forcing alignment; for uncached, `rd_addr` unchanged;
  - clears the beat counter (3 bits) and the 256-bit line buffer to 0.
- AR: `araddr`/`arlen` come from the latched registers and stay stable while `arvalid`=1. AR → R on `arready`.
- R: each `rvalid` cycle writes `rdata` into buffer word [beat counter], then increments the counter (wraps mod 8). R → RET on `rvalid && rlast`.
  - Termination is by `rlast` only.
  - Beats after the 8th would overwrite from word 0 (AXI-illegal; not otherwise handled).
- RET → IDLE unconditionally. `ret_data` is the buffer register.
  - For uncached requests the word is in [31:0] and bits [255:32] are 0.
  - `ret_data` holds its value after RET until the next accept.
- A new `rd_req` during AR/R/RET is not accepted (`rd_rdy`=0). The cache holds it until IDLE.
- Reset values:
  - state = IDLE.
  - `rd_rdy`=1 from the first cycle after reset.
  - `ret_valid`=0, `arvalid`=0, `rready`=0.
  - `ret_data`=0, `araddr`=0, `arlen`=0, beat counter = 0.
- Reset mid-transaction: the bridge returns to IDLE at the next edge and drops `arvalid`/`rready` immediately. The in-flight AXI transaction is abandoned; this is acceptable because the interconnect is reset together with the bridge.

## Timing
- Accept at edge T: `arvalid` is high in cycle T+1.
- AR handshake at edge A: `rready` is high from cycle A+1.
- Last beat at edge L: `ret_valid` is high in cycle L+1 only; `rd_rdy` is high from cycle L+2.
- Best-case line read (`arready` and `rvalid` always high):
  - accept at T;
  - AR handshake at T+1;
  - beats at T+2..T+9;
  - `ret_valid` in cycle T+10.
- Best-case uncached read: `ret_valid` in cycle T+3.
- Back-to-back requests are separated by at least the RET cycle plus one IDLE cycle.
- `rvalid` gaps (bubbles) only stall the counter; the beat order is preserved.

## Test plan
- Line read: `rd_type`=1, `rd_addr`=0x1FC0_0014, slave returns 0x11111111·k for k=1..8 → `araddr`=0x1FC0_0000, `arlen`=7, `arburst`=1, `arsize`=2; one `ret_valid` pulse with word0=0x11111111 … word7=0x88888888.
- Uncached read: `rd_type`=0, `rd_addr`=0xBFC0_0004, `rdata`=0xDEADBEEF → `araddr`=0xBFC0_0004, `arlen`=0; `ret_data`=0x…0000_DEADBEEF with the upper 224 bits 0; `ret_valid` 3 cycles after accept when the slave has zero wait states.
- Backpressure: `arready` low for 5 cycles, then random `rvalid` bubbles → `araddr`/`arlen` stable while `arvalid` is high; data is identical to the no-stall case; exactly one `ret_valid`.
- Request hold: `rd_req` asserted continuously with a second address while the first line is in flight → `rd_rdy`=0 until one cycle after `ret_valid`; the second AR is issued with the second address.
- Reset mid-burst: assert `resetn`=0 after beat 3 → next cycle shows state IDLE, `arvalid`=`rready`=`ret_valid`=0, `ret_data`=0, `rd_rdy`=1; a subsequent clean line read returns correct data.
